// File: rtl/fpu_arbiter_if.sv
// Requester/FPU bus bundle for fpu_arbiter: two requesters share one FP16 FPU.
// slave = arbiter view, master = environment (requesters + FPU) view.
interface fpu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        fpu_valid_in;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic        fpu_valid_out;
  logic [15:0] fpu_result;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_valid_out, fpu_result,
    output req_ready, fpu_valid_in, fpu_op, fpu_a, fpu_b,
           rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_valid_out, fpu_result,
    input  req_ready, fpu_valid_in, fpu_op, fpu_a, fpu_b,
           rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FP16 FPU between two requesters, one op in flight.
// Optional WAIT timeout with forced error response: define FPU_ARBITER_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst_n,
  fpu_arbiter_if.slave bus
);
  localparam int          NUM_REQ = 2;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][1:0]  op_v;
  logic [NUM_REQ-1:0][15:0] a_v, b_v;
  logic [NUM_REQ-1:0]       grant, acc;
  logic                     acc_any, acc_idx, acc_rsv;
  logic                     last;   // most recently accepted requester
  logic                     tag;    // owner of the op in flight
  logic                     ld_rsp, err_d, to_hit;
  logic [15:0]              data_d;

  assign op_v = bus.req_op;
  assign a_v  = bus.req_a;
  assign b_v  = bus.req_b;

  always_comb begin
    grant = '0;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign bus.req_ready[i] = (state == IDLE) && grant[i];
    assign bus.rsp_valid[i] = (state == RESP) && (tag == 1'(i));
    assign acc[i]           = bus.req_valid[i] && bus.req_ready[i];
  end

  assign acc_any          = |acc;
  assign acc_idx          = acc[1];
  assign acc_rsv          = (op_v[acc_idx] == 2'b11);
  assign bus.fpu_valid_in = (state == ISSUE);
  assign bus.busy         = (state != IDLE);

`ifdef FPU_ARBITER_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Cleared whenever outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state != WAIT)  to_cnt <= '0;
    else                     to_cnt <= to_cnt + 8'd1;
  end

  assign to_hit = (to_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ld_rsp    = 1'b0;
    data_d    = bus.rsp_data;
    err_d     = bus.rsp_err;
    case (state)
      IDLE: if (acc_any) begin
        if (acc_rsv) begin
          state_nxt = RESP;
          ld_rsp    = 1'b1;
          data_d    = QNAN;
          err_d     = 1'b1;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A reply in the same cycle as the timeout still wins.
        if (bus.fpu_valid_out) begin
          state_nxt = RESP;
          ld_rsp    = 1'b1;
          data_d    = bus.fpu_result;
          err_d     = 1'b0;
        end else if (to_hit) begin
          state_nxt = RESP;
          ld_rsp    = 1'b1;
          data_d    = QNAN;
          err_d     = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 1'b1;
      tag          <= 1'b0;
      bus.fpu_op   <= '0;
      bus.fpu_a    <= '0;
      bus.fpu_b    <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc_any) begin
        last <= acc_idx;
        tag  <= acc_idx;
        // Reserved ops never reach the FPU, so its operand bus is left untouched.
        if (!acc_rsv) begin
          bus.fpu_op <= op_v[acc_idx];
          bus.fpu_a  <= a_v[acc_idx];
          bus.fpu_b  <= b_v[acc_idx];
        end
      end
      if (ld_rsp) begin
        bus.rsp_data <= data_d;
        bus.rsp_err  <= err_d;
      end
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter (TIMEOUT=4); timeout path
// is exercised when FPU_ARBITER_TIMEOUT_EN is defined, else the stuck-busy path.
module tb_fpu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpu_arbiter_if bus ();

  fpu_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid     = 2'b00;
    bus.req_op        = 4'h0;
    bus.req_a         = 32'h0;
    bus.req_b         = 32'h0;
    bus.fpu_valid_out = 1'b0;
    bus.fpu_result    = 16'h0;

    // reset state
    step(); step(); smp();
    chk("rst_busy",   32'(bus.busy),         32'h0);
    chk("rst_fvin",   32'(bus.fpu_valid_in), 32'h0);
    chk("rst_rspv",   32'(bus.rsp_valid),    32'h0);
    chk("rst_rspd",   32'(bus.rsp_data),     32'h0);
    chk("rst_fpua",   32'(bus.fpu_a),        32'h0);
    chk("rst_ready",  32'(bus.req_ready),    32'h0);
    step(); rst_n = 1'b1; smp();
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    // round robin, both requesters continuously valid
    step();
    bus.req_valid = 2'b11;
    bus.req_op    = {2'b10, 2'b00};
    bus.req_a     = {16'h0003, 16'h0001};
    bus.req_b     = {16'h0004, 16'h0002};
    for (int k = 0; k < 6; k++) begin
      logic exp_i;
      exp_i = k[0];
      if (k > 0) step();
      smp();
      chk("rr_ready", 32'(bus.req_ready), exp_i ? 32'h2 : 32'h1);
      step(); smp();
      chk("rr_issue", 32'(bus.fpu_valid_in), 32'h1);
      chk("rr_fpua",  32'(bus.fpu_a), exp_i ? 32'h3 : 32'h1);
      chk("rr_nordy_issue", 32'(bus.req_ready), 32'h0);
      step();
      bus.fpu_valid_out = 1'b1;
      bus.fpu_result    = 16'(16'h0100 + k);
      smp();
      chk("rr_wait_fvin",   32'(bus.fpu_valid_in), 32'h0);
      chk("rr_nordy_wait",  32'(bus.req_ready), 32'h0);
      step();
      bus.fpu_valid_out = 1'b0;
      smp();
      chk("rr_rspv", 32'(bus.rsp_valid), exp_i ? 32'h2 : 32'h1);
      chk("rr_rspd", 32'(bus.rsp_data), 32'(16'h0100 + k));
      chk("rr_nordy_resp", 32'(bus.req_ready), 32'h0);
    end
    step(); bus.req_valid = 2'b00; smp();
    chk("rr_done_busy", 32'(bus.busy), 32'h0);

    // requester 0 add, FPU replies 2 cycles after issue
    step();
    bus.req_valid = 2'b01;
    bus.req_op    = 4'b0000;
    bus.req_a     = {16'h0000, 16'h3C00};
    bus.req_b     = {16'h0000, 16'h4000};
    smp();
    chk("add_ready", 32'(bus.req_ready), 32'h1);
    step(); bus.req_valid = 2'b00; smp();
    chk("add_fvin", 32'(bus.fpu_valid_in), 32'h1);
    chk("add_fop",  32'(bus.fpu_op), 32'h0);
    chk("add_fpua", 32'(bus.fpu_a), 32'h3C00);
    chk("add_fpub", 32'(bus.fpu_b), 32'h4000);
    step(); smp();
    chk("add_fvin_once", 32'(bus.fpu_valid_in), 32'h0);
    chk("add_busy", 32'(bus.busy), 32'h1);
    step(); bus.fpu_valid_out = 1'b1; bus.fpu_result = 16'h4200; smp();
    chk("add_not_early", 32'(bus.rsp_valid), 32'h0);
    step(); bus.fpu_valid_out = 1'b0; smp();
    chk("add_rspv", 32'(bus.rsp_valid), 32'h1);
    chk("add_rspd", 32'(bus.rsp_data), 32'h4200);
    chk("add_err",  32'(bus.rsp_err), 32'h0);
    chk("add_fpua_hold", 32'(bus.fpu_a), 32'h3C00);
    step(); smp();
    chk("add_rspv_once", 32'(bus.rsp_valid), 32'h0);
    chk("add_idle", 32'(bus.busy), 32'h0);
    chk("add_rspd_hold", 32'(bus.rsp_data), 32'h4200);

    // stray FPU strobe while idle
    step(); bus.fpu_valid_out = 1'b1; bus.fpu_result = 16'h1234; smp();
    step(); bus.fpu_valid_out = 1'b0; smp();
    chk("stray_busy", 32'(bus.busy), 32'h0);
    chk("stray_rspv", 32'(bus.rsp_valid), 32'h0);
    chk("stray_rspd", 32'(bus.rsp_data), 32'h4200);

    // request withdrawn before the accepting edge
    step(); bus.req_valid = 2'b01; smp();
    chk("drop_ready", 32'(bus.req_ready), 32'h1);
    #1 bus.req_valid = 2'b00;
    step(); smp();
    chk("drop_busy", 32'(bus.busy), 32'h0);

    // reserved op from requester 1
    step(); bus.req_valid = 2'b10; bus.req_op = {2'b11, 2'b00}; smp();
    chk("rsv_ready", 32'(bus.req_ready), 32'h2);
    step(); bus.req_valid = 2'b00; smp();
    chk("rsv_rspv", 32'(bus.rsp_valid), 32'h2);
    chk("rsv_err",  32'(bus.rsp_err), 32'h1);
    chk("rsv_rspd", 32'(bus.rsp_data), 32'h7E00);
    chk("rsv_fvin", 32'(bus.fpu_valid_in), 32'h0);
    step(); smp();
    chk("rsv_idle", 32'(bus.busy), 32'h0);
    chk("rsv_fvin_after", 32'(bus.fpu_valid_in), 32'h0);

    // FPU never replies
    step();
    bus.req_valid = 2'b01;
    bus.req_op    = 4'b0001;
    bus.req_a     = {16'h0000, 16'h0005};
    bus.req_b     = {16'h0000, 16'h0006};
    smp();
    step(); bus.req_valid = 2'b00; smp();
    chk("to_fop",  32'(bus.fpu_op), 32'h1);
    chk("to_fvin", 32'(bus.fpu_valid_in), 32'h1);
`ifdef FPU_ARBITER_TIMEOUT_EN
    for (int w = 0; w < 4; w++) begin
      step(); smp();
      chk("to_wait_rspv", 32'(bus.rsp_valid), 32'h0);
      chk("to_wait_busy", 32'(bus.busy), 32'h1);
    end
    step(); smp();
    chk("to_rspv", 32'(bus.rsp_valid), 32'h1);
    chk("to_err",  32'(bus.rsp_err), 32'h1);
    chk("to_rspd", 32'(bus.rsp_data), 32'h7E00);
    step(); smp();
    chk("to_idle", 32'(bus.busy), 32'h0);
    step(); bus.req_valid = 2'b01; bus.req_op = 4'b0000; smp();
    step(); bus.req_valid = 2'b00; smp();
    step(); smp();
`else
    for (int w = 0; w < 40; w++) begin
      step(); smp();
    end
    chk("stuck_busy", 32'(bus.busy), 32'h1);
    chk("stuck_rspv", 32'(bus.rsp_valid), 32'h0);
`endif

    // reset pulse during WAIT, then a late FPU reply
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    step(); rst_n = 1'b0; smp();
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_rspv", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_fvin", 32'(bus.fpu_valid_in), 32'h0);
    chk("mid_rst_fpua", 32'(bus.fpu_a), 32'h0);
    chk("mid_rst_rspd", 32'(bus.rsp_data), 32'h0);
    chk("mid_rst_err",  32'(bus.rsp_err), 32'h0);
    step(); rst_n = 1'b1; bus.fpu_valid_out = 1'b1; bus.fpu_result = 16'hBEEF; smp();
    chk("late_busy", 32'(bus.busy), 32'h0);
    step(); bus.fpu_valid_out = 1'b0; smp();
    chk("late_rspv", 32'(bus.rsp_valid), 32'h0);
    chk("late_rspd", 32'(bus.rsp_data), 32'h0);
    step(); bus.req_valid = 2'b11; smp();
    chk("tie_after_rst", 32'(bus.req_ready), 32'h1);
    step(); bus.req_valid = 2'b00; smp();
    chk("tie_busy", 32'(bus.busy), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles before a forced error response (range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-006 SHALL have port req_op  input  4  operation code per requester, {op1,op0}: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-007 SHALL have port req_a  input  32  FP16 operand A per requester, {a1,a0}.
REQ-008 SHALL have port req_b  input  32  FP16 operand B per requester, {b1,b0}.
REQ-009 SHALL have port fpu_valid_in  output  1  single-cycle issue strobe to the shared FPU.
REQ-010 SHALL have port fpu_op  output  2  operation code presented to the FPU (00/01/10 only).
REQ-011 SHALL have port fpu_a  output  16  registered operand A to the FPU.
REQ-012 SHALL have port fpu_b  output  16  registered operand B to the FPU.
REQ-013 SHALL have port fpu_valid_out  input  1  FPU result strobe.
REQ-014 SHALL have port fpu_result  input  16  FPU result, sampled when fpu_valid_out is high.
REQ-015 SHALL have port rsp_valid  output  2  single-cycle response strobe to the owning requester.
REQ-016 SHALL have port rsp_data  output  16  response data, shared by both requesters.
REQ-017 SHALL have port rsp_err  output  1  response error flag, qualified by rsp_valid.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with exactly one operation outstanding at a time.
REQ-020 In IDLE, req_ready SHALL be high only for the granted requester; req_ready SHALL be 0 in all other states.
REQ-021 Grant SHALL be round-robin: with one request pending, that requester wins; with both pending, the requester not most recently accepted wins; after reset, requester 0 wins a tie.
REQ-022 On accept, the block SHALL register op, a, b and the owner tag and move to ISSUE next cycle.
REQ-023 If the accepted op is 11, the block SHALL skip ISSUE/WAIT, go directly to RESP with rsp_err=1 and rsp_data=16'h7E00, and leave fpu_valid_in low.
REQ-024 In ISSUE, fpu_valid_in SHALL be 1 for exactly one cycle with fpu_op/fpu_a/fpu_b equal to the registered values; the next state SHALL be WAIT.
REQ-025 fpu_op, fpu_a and fpu_b SHALL hold their values from ISSUE until the next accept.
REQ-026 In WAIT, on fpu_valid_out=1 the block SHALL capture fpu_result and enter RESP next cycle with rsp_err=0.
REQ-027 fpu_valid_out SHALL be ignored in IDLE, ISSUE and RESP.
REQ-028 In RESP, rsp_valid[tag] SHALL be 1 for one cycle with rsp_data and rsp_err valid, and the other rsp_valid bit SHALL be 0; the next state SHALL be IDLE.
REQ-029 Accept-to-response latency SHALL be 3 + N cycles, where N is the number of WAIT cycles (N ≥ 1).
REQ-030 A requester dropping req_valid before accept SHALL not be granted, and no state SHALL change as a result.
REQ-031 rsp_data SHALL hold its last value outside RESP.

Reset
REQ-032 Asserting rst_n low SHALL at any time, including mid-operation, force:
- state to IDLE;
- fpu_valid_in, rsp_valid, rsp_err and busy to 0;
- fpu_op, fpu_a, fpu_b and rsp_data to 0;
- the round-robin pointer to favour requester 0;
- the timeout counter to 0.
REQ-033 An in-flight operation interrupted by reset SHALL produce no response, and a late fpu_valid_out after reset SHALL be ignored.

Configuration
REQ-034 With macro FPU_ARBITER_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if it reaches TIMEOUT with no fpu_valid_out, the block SHALL enter RESP with rsp_err=1 and rsp_data=16'h7E00.
REQ-035 With FPU_ARBITER_TIMEOUT_EN undefined, the counter SHALL not exist and WAIT SHALL persist until fpu_valid_out.

Verification
REQ-036 Requester 0 only, op=00, a=16'h3C00, b=16'h4000, FPU replies 2 cycles after issue with 16'h4200 -> rsp_valid=01, rsp_data=16'h4200, rsp_err=0, latency 5 cycles.
REQ-037 Both requesters valid continuously, three operations each -> accept order 0,1,0,1,0,1; never two outstanding.
REQ-038 Requester 1 op=11 -> fpu_valid_in never asserted; rsp_valid=10 two cycles after accept with rsp_err=1 and rsp_data=16'h7E00.
REQ-039 TIMEOUT=4 with the macro defined and the FPU never replying -> rsp_err=1, rsp_data=16'h7E00 after 4 WAIT cycles; without the macro, busy stays 1 indefinitely.
REQ-040 rst_n pulsed low during WAIT, then fpu_valid_out asserted -> no rsp_valid, busy=0, and the next tie is granted to requester 0.
